// File: rtl/gcd_binary.sv
// Stein's binary GCD: strip common factors of two, reduce the odd remainders by
// shift/subtract, then restore the common power of two into the result.
module gcd_binary #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StAlign, StReduce, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d = A;
          b_d = B;
          k_d = '0;
          // A zero operand makes the other operand the answer; skip straight to DONE.
          if ((A == '0) || (B == '0)) begin
            y_d     = A | B;
            state_d = StDone;
          end else begin
            state_d = StAlign;
          end
        end
      end
      StAlign: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (a_q == b_q) begin
          y_d     = a_q << k_q;
          state_d = StDone;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Y    = y_q;
  assign busy = (state_q == StAlign) || (state_q == StReduce);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_gcd_binary.sv
// Bench for gcd_binary: an 8-bit and a 16-bit instance checked every cycle against
// a transaction-level model, plus directed vectors with hand-computed results.
module tb_gcd_binary;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, y8;
  logic        busy8, done8;
  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, y16;
  logic        busy16, done16;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: phase 0 idle, 1 busy, 2 done.
  int          m_ph[2];
  int          m_cnt[2];
  int unsigned m_g[2];
  int unsigned m_y[2];

  always #5 clock = ~clock;

  gcd_binary #(.WIDTH(8)) u_w8 (
    .clock(clock), .reset(reset), .start(s8), .A(a8), .B(b8),
    .Y(y8), .busy(busy8), .done(done8)
  );

  gcd_binary #(.WIDTH(16)) u_w16 (
    .clock(clock), .reset(reset), .start(s16), .A(a16), .B(b16),
    .Y(y16), .busy(busy16), .done(done16)
  );

  function automatic int unsigned euclid(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Cycles spent in ALIGN plus REDUCE for nonzero operands.
  function automatic int stein_cycles(input int unsigned x, input int unsigned y);
    int n = 0;
    forever begin
      n++;
      if ((x % 2 == 0) && (y % 2 == 0)) begin
        x = x / 2;
        y = y / 2;
      end else break;
    end
    forever begin
      n++;
      if (x == y) break;
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = x - y;
      else y = y - x;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int i, input logic s, input int unsigned a, input int unsigned b);
    if (!reset) begin
      m_ph[i]  = 0;
      m_cnt[i] = 0;
      m_y[i]   = 0;
    end else begin
      case (m_ph[i])
        0: if (s) begin
          if (a == 0 || b == 0) begin
            m_y[i]  = a | b;
            m_ph[i] = 2;
          end else begin
            m_ph[i]  = 1;
            m_cnt[i] = stein_cycles(a, b);
            m_g[i]   = euclid(a, b);
          end
        end
        1: begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_ph[i] = 2;
            m_y[i]  = m_g[i];
          end
        end
        default: m_ph[i] = 0;
      endcase
    end
  endtask

  always @(posedge clock or negedge reset) begin
    step(0, s8, a8, b8);
    step(1, s16, a16, b16);
  end

  always @(negedge clock) begin
    chk("w8_busy", busy8, m_ph[0] == 1);
    chk("w8_done", done8, m_ph[0] == 2);
    chk("w8_y", y8, m_y[0]);
    chk("w16_busy", busy16, m_ph[1] == 1);
    chk("w16_done", done16, m_ph[1] == 2);
    chk("w16_y", y16, m_y[1]);
  end

  task automatic run8(input int unsigned a, input int unsigned b, input int unsigned ey,
                      input int el, input string nm);
    int n = 0;
    @(negedge clock);
    while (busy8 || done8) @(negedge clock);
    a8 = 8'(a); b8 = 8'(b); s8 = 1'b1;
    @(posedge clock);
    #1 s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    @(negedge clock);
    while (!done8 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_done_seen"}, done8, 1);
    chk({nm, "_y"}, y8, ey);
    if (el >= 0) chk({nm, "_lat"}, n, el);
  endtask

  task automatic run16(input int unsigned a, input int unsigned b, input int unsigned ey,
                       input int el, input string nm);
    int n = 0;
    @(negedge clock);
    while (busy16 || done16) @(negedge clock);
    a16 = 16'(a); b16 = 16'(b); s16 = 1'b1;
    @(posedge clock);
    #1 s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    @(negedge clock);
    while (!done16 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_done_seen"}, done16, 1);
    chk({nm, "_y"}, y16, ey);
    if (el >= 0) chk({nm, "_lat"}, n, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("model_gcd_12_18", euclid(12, 18), 6);
    chk("model_lat_12_18", stein_cycles(12, 18), 6);
    chk("model_lat_200_150", stein_cycles(200, 150), 7);
    #23;
    chk("rst_y8", y8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_y16", y16, 0);
    reset = 1'b1;

    run8(12, 18, 6, 6, "g12_18");
    run8(0, 5, 5, 0, "g0_5");
    run8(0, 0, 0, 0, "g0_0");
    run8(7, 7, 7, 2, "g7_7");
    run8(13, 1, 1, 7, "g13_1");
    run8(5, 0, 5, 0, "g5_0");
    run8(255, 255, 255, 2, "g255_255");
    run8(255, 254, 1, -1, "g255_254");
    run8(128, 96, 32, -1, "g128_96");
    run16(16'h8000, 16'h8000, 16'h8000, 17, "w16_pow");
    run16(16'hFFFF, 16'hFFFE, 1, -1, "w16_ffff");
    run16(1000, 600, 200, -1, "w16_1000_600");

    // Held start and start pulses while busy; the model enforces one run per IDLE visit.
    @(negedge clock);
    a8 = 8'd12; b8 = 8'd18; s8 = 1'b1;
    a16 = 16'd84; b16 = 16'd36; s16 = 1'b1;
    repeat (40) @(negedge clock);
    s8 = 1'b0; s16 = 1'b0;
    repeat (3) @(negedge clock);
    a8 = 8'd45; b8 = 8'd30; s8 = 1'b1;
    @(negedge clock);
    s8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      s8 = (i % 2 == 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    s8 = 1'b0;
    repeat (20) @(negedge clock);

    // Reset in the middle of REDUCE aborts with no done.
    a8 = 8'd200; b8 = 8'd150; s8 = 1'b1;
    @(posedge clock);
    #1 s8 = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_rst_busy", busy8, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_y", y8, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    run8(200, 150, 50, 7, "g200_150");
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
